// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding fetch unit with redirect/kill handling; FETCH_MISALIGN_CHECK_EN traps misaligned redirect targets
module instruction_fetch #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_en,
  input  logic            decode_ready,
  input  logic            redirect_en,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] curr_pc_fd,
  output logic [XLEN-1:0] next_pc_fd,
  output logic            inst_valid,
  output logic            inst_misalign
);
  localparam logic [31:0] NOP = 32'h0000_0013;
  typedef enum logic [1:0] {IDLE, REQ, FULL} state_t;
  state_t state_q, state_d, go;
  logic [XLEN-1:0] pc_q, pc_d, tgt_q, tgt_d, curr_q, curr_d, next_q, next_d;
  logic [XLEN-1:0] rpc, jmp;
  logic [31:0] inst_q, inst_d;
  logic kill_q, kill_d, valid_q, valid_d, mis_q, mis_d;
  logic take, jmp_mis;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign rpc = redirect_pc;
`else
  assign rpc = redirect_pc & ~XLEN'(3);
`endif
  // a killed request that finally gets its ack jumps to the pending target unless a newer redirect arrives
  assign jmp = (state_q == REQ && !redirect_en) ? tgt_q : rpc;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign jmp_mis = |jmp[1:0];
`else
  assign jmp_mis = 1'b0;
`endif
  assign imem_req      = (state_q == REQ);
  assign imem_addr     = pc_q;
  assign inst          = inst_q;
  assign curr_pc_fd    = curr_q;
  assign next_pc_fd    = next_q;
  assign inst_valid    = valid_q;
  assign inst_misalign = mis_q;
  // next-state: request tracking, capture, consume, and redirect application
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    tgt_d   = tgt_q;
    kill_d  = kill_q;
    inst_d  = inst_q;
    curr_d  = curr_q;
    next_d  = next_q;
    valid_d = valid_q;
    mis_d   = mis_q;
    take    = 1'b0;
    go      = fetch_en ? REQ : IDLE;
    unique case (state_q)
      IDLE: begin
        take = redirect_en;
        if (!redirect_en && fetch_en) state_d = REQ;
      end
      REQ: begin
        if (imem_ack && (kill_q || redirect_en)) begin
          kill_d = 1'b0;
          take   = 1'b1;
          go     = REQ;
        end else if (imem_ack) begin
          inst_d  = imem_rdata;
          curr_d  = pc_q;
          next_d  = pc_q + XLEN'(4);
          valid_d = 1'b1;
          state_d = FULL;
        end else if (redirect_en) begin
          tgt_d  = rpc;
          kill_d = 1'b1;
        end
      end
      FULL: begin
        take = redirect_en;
        if (redirect_en || decode_ready) begin
          valid_d = 1'b0;
          mis_d   = 1'b0;
          pc_d    = pc_q + XLEN'(4);
          state_d = go;
        end
      end
      default: state_d = IDLE;
    endcase
    if (take) begin
      pc_d    = {jmp[XLEN-1:2], 2'b00};
      state_d = jmp_mis ? FULL : go;
      if (jmp_mis) begin
        inst_d  = NOP;
        curr_d  = jmp;
        next_d  = jmp + XLEN'(4);
        valid_d = 1'b1;
        mis_d   = 1'b1;
      end
    end
  end
  // state and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_VECTOR;
      tgt_q   <= '0;
      kill_q  <= 1'b0;
      inst_q  <= NOP;
      curr_q  <= '0;
      next_q  <= '0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      tgt_q   <= tgt_d;
      kill_q  <= kill_d;
      inst_q  <= inst_d;
      curr_q  <= curr_d;
      next_q  <= next_d;
      valid_q <= valid_d;
      mis_q   <= mis_d;
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed scenarios plus randomized run against a transaction-level fetch model
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0, rst = 1'b1, fetch_en = 1'b0, decode_ready = 1'b0, redirect_en = 1'b0, imem_ack = 1'b0;
  logic [31:0] redirect_pc = '0, imem_rdata = '0;
  logic imem_req, inst_valid, inst_misalign;
  logic [31:0] imem_addr, inst, curr_pc_fd, next_pc_fd;
  int vectors = 0, errors = 0;
  always #5 clk = ~clk;
  instruction_fetch #(.XLEN(32), .RESET_VECTOR(32'h0)) dut (
    .clk(clk), .rst(rst), .fetch_en(fetch_en), .decode_ready(decode_ready),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst),
    .curr_pc_fd(curr_pc_fd), .next_pc_fd(next_pc_fd), .inst_valid(inst_valid),
    .inst_misalign(inst_misalign)
  );
  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset;
    fetch_en = 0; decode_ready = 0; redirect_en = 0; imem_ack = 0; redirect_pc = 0; imem_rdata = 0;
    rst = 1;
    tick;
    tick;
    rst = 0;
  endtask
  task automatic test_reset;
    rst = 1;
    tick;
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL reset_req got %0b exp 0", imem_req); end
    vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got %h exp 0", imem_addr); end
    vectors++; if (inst !== NOP) begin errors++; $display("FAIL reset_inst got %h exp %h", inst, NOP); end
    vectors++; if (curr_pc_fd !== 32'h0) begin errors++; $display("FAIL reset_curr got %h exp 0", curr_pc_fd); end
    vectors++; if (next_pc_fd !== 32'h0) begin errors++; $display("FAIL reset_next got %h exp 0", next_pc_fd); end
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", inst_valid); end
    vectors++; if (inst_misalign !== 1'b0) begin errors++; $display("FAIL reset_mis got %0b exp 0", inst_misalign); end
    rst = 0; fetch_en = 1;
    tick;
    vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL midreq_req got %0b exp 1", imem_req); end
    #2 rst = 1;
    #1;
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL async_rst_req got %0b exp 0", imem_req); end
    @(negedge clk);
    rst = 0; fetch_en = 0; imem_ack = 1; imem_rdata = 32'hBADC0DE0;
    tick;
    imem_ack = 0;
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL stray_ack_valid got %0b exp 0", inst_valid); end
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL stray_ack_req got %0b exp 0", imem_req); end
  endtask
  task automatic test_zero_latency;
    do_reset;
    fetch_en = 1; decode_ready = 1; imem_rdata = 32'h0010_0093;
    tick;
    for (int i = 0; i < 3; i++) begin
      vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL zl_req[%0d] got %0b exp 1", i, imem_req); end
      vectors++; if (imem_addr !== 32'(4 * i)) begin errors++; $display("FAIL zl_addr[%0d] got %h exp %h", i, imem_addr, 32'(4 * i)); end
      imem_ack = 1;
      tick;
      imem_ack = 0;
      vectors++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL zl_valid[%0d] got %0b exp 1", i, inst_valid); end
      vectors++; if (inst !== 32'h0010_0093) begin errors++; $display("FAIL zl_inst[%0d] got %h exp 00100093", i, inst); end
      vectors++; if (curr_pc_fd !== 32'(4 * i)) begin errors++; $display("FAIL zl_curr[%0d] got %h exp %h", i, curr_pc_fd, 32'(4 * i)); end
      vectors++; if (next_pc_fd !== 32'(4 * i + 4)) begin errors++; $display("FAIL zl_next[%0d] got %h exp %h", i, next_pc_fd, 32'(4 * i + 4)); end
      tick;
    end
  endtask
  task automatic test_wait_states;
    do_reset;
    fetch_en = 1;
    tick;
    for (int j = 0; j < 3; j++) begin
      vectors++; if (imem_req !== 1'b1) begin errors++; $display("FAIL ws_req[%0d] got %0b exp 1", j, imem_req); end
      vectors++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL ws_addr[%0d] got %h exp 0", j, imem_addr); end
      vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ws_valid[%0d] got %0b exp 0", j, inst_valid); end
      tick;
    end
    imem_ack = 1; imem_rdata = 32'hA5A5_5A5A;
    tick;
    imem_ack = 0; fetch_en = 0;
    vectors++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL ws_cap_valid got %0b exp 1", inst_valid); end
    vectors++; if (inst !== 32'hA5A5_5A5A) begin errors++; $display("FAIL ws_cap_inst got %h exp a5a55a5a", inst); end
    decode_ready = 1;
    tick;
    decode_ready = 0;
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL ws_once_valid got %0b exp 0", inst_valid); end
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL ws_idle_req got %0b exp 0", imem_req); end
    vectors++; if (imem_addr !== 32'h4) begin errors++; $display("FAIL ws_idle_addr got %h exp 4", imem_addr); end
  endtask
  task automatic test_stall;
    do_reset;
    fetch_en = 1;
    tick;
    imem_ack = 1; imem_rdata = 32'h1234_5678;
    tick;
    imem_ack = 0;
    for (int j = 0; j < 5; j++) begin
      vectors++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL st_valid[%0d] got %0b exp 1", j, inst_valid); end
      vectors++; if (inst !== 32'h1234_5678) begin errors++; $display("FAIL st_inst[%0d] got %h exp 12345678", j, inst); end
      vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL st_req[%0d] got %0b exp 0", j, imem_req); end
      tick;
    end
    decode_ready = 1;
    tick;
    decode_ready = 0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) begin errors++; $display("FAIL st_resume got req %0b addr %h exp req 1 addr 4", imem_req, imem_addr); end
  endtask
  task automatic test_redirect_wait;
    do_reset;
    fetch_en = 1;
    tick;
    redirect_en = 1; redirect_pc = 32'h100;
    tick;
    redirect_en = 0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL rw_hold got req %0b addr %h exp req 1 addr 0", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF;
    tick;
    imem_ack = 0;
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_discard_valid got %0b exp 0", inst_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL rw_readdr got req %0b addr %h exp req 1 addr 100", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0001_3579;
    tick;
    imem_ack = 0;
    vectors++; if (inst_valid !== 1'b1 || inst !== 32'h0001_3579 || curr_pc_fd !== 32'h100) begin errors++; $display("FAIL rw_new got v %0b inst %h pc %h exp v 1 inst 00013579 pc 100", inst_valid, inst, curr_pc_fd); end
    decode_ready = 1;
    tick;
    decode_ready = 0; redirect_en = 1; redirect_pc = 32'h200; imem_ack = 1; imem_rdata = 32'hBAD0_BAD0;
    tick;
    redirect_en = 0; imem_ack = 0;
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rw_same_valid got %0b exp 0", inst_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rw_same_addr got req %0b addr %h exp req 1 addr 200", imem_req, imem_addr); end
  endtask
  task automatic test_redirect_full;
    do_reset;
    fetch_en = 1;
    tick;
    imem_ack = 1; imem_rdata = 32'h0000_0033;
    tick;
    imem_ack = 0; redirect_en = 1; decode_ready = 1; redirect_pc = 32'h40;
    tick;
    redirect_en = 0; decode_ready = 0;
    vectors++; if (inst_valid !== 1'b0) begin errors++; $display("FAIL rf_valid got %0b exp 0", inst_valid); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h40) begin errors++; $display("FAIL rf_addr got req %0b addr %h exp req 1 addr 40", imem_req, imem_addr); end
  endtask
  task automatic test_misalign;
    do_reset;
    fetch_en = 1;
    tick;
    imem_ack = 1;
    tick;
    imem_ack = 0; redirect_en = 1; redirect_pc = 32'h102;
    tick;
    redirect_en = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
    vectors++; if (imem_req !== 1'b0) begin errors++; $display("FAIL mis_req got %0b exp 0", imem_req); end
    vectors++; if (inst_valid !== 1'b1 || inst !== NOP) begin errors++; $display("FAIL mis_inst got v %0b inst %h exp v 1 inst 00000013", inst_valid, inst); end
    vectors++; if (inst_misalign !== 1'b1) begin errors++; $display("FAIL mis_flag got %0b exp 1", inst_misalign); end
    vectors++; if (curr_pc_fd !== 32'h102) begin errors++; $display("FAIL mis_curr got %h exp 102", curr_pc_fd); end
    decode_ready = 1;
    tick;
    decode_ready = 0;
    vectors++; if (inst_misalign !== 1'b0) begin errors++; $display("FAIL mis_clear got %0b exp 0", inst_misalign); end
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h104) begin errors++; $display("FAIL mis_resume got req %0b addr %h exp req 1 addr 104", imem_req, imem_addr); end
`else
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL mis_force got req %0b addr %h exp req 1 addr 100", imem_req, imem_addr); end
    vectors++; if (inst_misalign !== 1'b0) begin errors++; $display("FAIL mis_tied got %0b exp 0", inst_misalign); end
`endif
  endtask
  task automatic test_wrap;
    do_reset;
    fetch_en = 1; redirect_en = 1; redirect_pc = 32'hFFFF_FFFC;
    tick;
    redirect_en = 0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got req %0b addr %h exp req 1 addr fffffffc", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0000_0073;
    tick;
    imem_ack = 0;
    vectors++; if (curr_pc_fd !== 32'hFFFF_FFFC || next_pc_fd !== 32'h0) begin errors++; $display("FAIL wr_pcs got curr %h next %h exp curr fffffffc next 0", curr_pc_fd, next_pc_fd); end
    decode_ready = 1;
    tick;
    decode_ready = 0;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL wr_next got req %0b addr %h exp req 1 addr 0", imem_req, imem_addr); end
  endtask
  task automatic test_fetch_en_hold;
    do_reset;
    fetch_en = 1;
    tick;
    fetch_en = 0;
    tick;
    tick;
    vectors++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin errors++; $display("FAIL fe_hold got req %0b addr %h exp req 1 addr 0", imem_req, imem_addr); end
    imem_ack = 1; imem_rdata = 32'h0000_1111;
    tick;
    imem_ack = 0;
    vectors++; if (inst_valid !== 1'b1) begin errors++; $display("FAIL fe_cap got %0b exp 1", inst_valid); end
    decode_ready = 1;
    tick;
    decode_ready = 0;
    tick;
    vectors++; if (imem_req !== 1'b0 || inst_valid !== 1'b0) begin errors++; $display("FAIL fe_idle got req %0b valid %0b exp 0 0", imem_req, inst_valid); end
  endtask
  task automatic test_random;
    bit busy, doom, held;
    logic [31:0] addr, tgt, minst, curr, tnew;
    busy = 0; doom = 0; held = 0; addr = 0; tgt = 0; minst = NOP; curr = 0;
    do_reset;
    for (int i = 0; i < 3000; i++) begin
      vectors++; if (imem_req !== busy) begin errors++; $display("FAIL rnd_req[%0d] got %0b exp %0b", i, imem_req, busy); end
      if (busy) begin
        vectors++; if (imem_addr !== addr) begin errors++; $display("FAIL rnd_addr[%0d] got %h exp %h", i, imem_addr, addr); end
      end
      vectors++; if (inst_valid !== held) begin errors++; $display("FAIL rnd_valid[%0d] got %0b exp %0b", i, inst_valid, held); end
      if (held) begin
        vectors++; if (inst !== minst || curr_pc_fd !== curr || next_pc_fd !== curr + 32'd4) begin errors++; $display("FAIL rnd_data[%0d] got %h/%h/%h exp %h/%h/%h", i, inst, curr_pc_fd, next_pc_fd, minst, curr, curr + 32'd4); end
      end
      vectors++; if (inst_misalign !== 1'b0) begin errors++; $display("FAIL rnd_mis[%0d] got %0b exp 0", i, inst_misalign); end
      fetch_en = ($urandom % 4) != 0;
      decode_ready = 1'($urandom % 2);
      redirect_en = ($urandom % 8) == 0;
      redirect_pc = $urandom;
`ifdef FETCH_MISALIGN_CHECK_EN
      redirect_pc[1:0] = 2'b00;
`endif
      imem_ack = busy ? (($urandom % 3) == 0) : (($urandom % 16) == 0);
      imem_rdata = $urandom;
      tnew = redirect_pc & ~32'd3;
      if (busy) begin
        if (imem_ack && (doom || redirect_en)) begin
          addr = redirect_en ? tnew : tgt;
          doom = 0;
        end else if (imem_ack) begin
          held = 1; busy = 0; minst = imem_rdata; curr = addr;
        end else if (redirect_en) begin
          doom = 1; tgt = tnew;
        end
      end else if (held) begin
        if (redirect_en || decode_ready) begin
          held = 0; addr = redirect_en ? tnew : curr + 32'd4; busy = fetch_en;
        end
      end else begin
        if (redirect_en) addr = tnew;
        busy = fetch_en;
      end
      tick;
    end
    fetch_en = 0; decode_ready = 0; redirect_en = 0; imem_ack = 0;
  endtask
  initial begin
    test_reset;
    test_zero_latency;
    test_wait_states;
    test_stall;
    test_redirect_wait;
    test_redirect_full;
    test_misalign;
    test_wrap;
    test_fetch_en_hold;
    test_random;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
